// File: rtl/cam_capture_pkg.sv
// Shared eye-tracker definitions: capture FSM state encoding and default camera geometry.
// Latency: not applicable (types and constants only).
// Backpressure: not applicable.
package cam_capture_pkg;

    localparam int DEF_PIXEL_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH  = 9;
    localparam int DEF_HACT        = 320;
    localparam int DEF_VACT        = 480;

    localparam int LINE_NUM_W      = 10;
    localparam int FRAME_CNT_W     = 8;

    // SYNC waits for a frame gap after reset, IDLE waits for a frame start,
    // ACTIVE captures lines until the frame ends.
    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } cap_state_e;

endpackage

// File: rtl/cam_capture.sv
// Stereo camera capture: turns FVAL/LVAL/DVAL pixel stream into line-buffer writes plus frame/line events.
// Latency: fixed 2 CCLK cycles from camera inputs to every output (input register + output register).
// Backpressure: none; the camera cannot be stalled, pixels past HACT or lines past VACT are dropped with OVF.
module cam_capture
    import cam_capture_pkg::*;
#(
    parameter int PIXEL_WIDTH = DEF_PIXEL_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int HACT        = DEF_HACT,
    parameter int VACT        = DEF_VACT
) (
    input  logic                   CCLK,
    input  logic                   RST_N,
    input  logic                   FVAL,
    input  logic                   LVAL,
    input  logic                   DVAL,
    input  logic [PIXEL_WIDTH-1:0] DATA_L,
    input  logic [PIXEL_WIDTH-1:0] DATA_R,
    output logic                   WR_EN,
    output logic [ADDR_WIDTH-1:0]  WR_ADDR,
    output logic [PIXEL_WIDTH-1:0] WR_DATA_L,
    output logic [PIXEL_WIDTH-1:0] WR_DATA_R,
    output logic [LINE_NUM_W-1:0]  LINE_NUM,
    output logic                   FRAME_START,
    output logic                   LINE_END,
    output logic                   FRAME_END,
    output logic [ADDR_WIDTH:0]    LINE_LEN,
    output logic [FRAME_CNT_W-1:0] FRAME_CNT,
    output logic                   OVF
);

    // Pixel counter is one bit wider than the address so it can count past HACT.
    localparam int                   CW      = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]        CNT_MAX = '1;
    localparam logic [CW-1:0]        HACT_C  = CW'(HACT);
    localparam logic [LINE_NUM_W-1:0] VACT_C = LINE_NUM_W'(VACT);

    // Stage 1: registered camera inputs and their one-cycle-old copies for edge detection.
    logic                   fval_q, lval_q, dval_q;
    logic                   fval_prev_q, lval_prev_q;
    logic [PIXEL_WIDTH-1:0] data_l_q, data_r_q;
    // Set one cycle after reset release, so the reset value of fval_q is not mistaken for a frame gap.
    logic                   armed_q;

    cap_state_e state_q, state_d;

    // Stage 2: output registers and datapath state.
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [PIXEL_WIDTH-1:0] wr_data_l_q, wr_data_l_d;
    logic [PIXEL_WIDTH-1:0] wr_data_r_q, wr_data_r_d;
    logic [LINE_NUM_W-1:0]  line_num_q, line_num_d;
    logic                   frame_start_q, frame_start_d;
    logic                   line_end_q, line_end_d;
    logic                   frame_end_q, frame_end_d;
    logic [CW-1:0]          line_len_q, line_len_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   ovf_q, ovf_d;
    logic [CW-1:0]          pix_cnt_q, pix_cnt_d;

    logic fval_rise;
    logic frame_open, frame_close, line_close, pix_en;

    // Capture the camera inputs once and keep the previous sample for edge detection.
    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            dval_q      <= 1'b0;
            fval_prev_q <= 1'b0;
            lval_prev_q <= 1'b0;
            data_l_q    <= '0;
            data_r_q    <= '0;
            armed_q     <= 1'b0;
        end else begin
            fval_q      <= FVAL;
            lval_q      <= LVAL;
            dval_q      <= DVAL;
            fval_prev_q <= fval_q;
            lval_prev_q <= lval_q;
            data_l_q    <= DATA_L;
            data_r_q    <= DATA_R;
            armed_q     <= 1'b1;
        end
    end

    assign fval_rise = fval_q & ~fval_prev_q;

    // FSM state register.
    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_SYNC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a frame in progress at reset release is skipped until FVAL has been seen low.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SYNC:   if (armed_q && !fval_q) state_d = ST_IDLE;
            ST_IDLE:   if (fval_rise)          state_d = ST_ACTIVE;
            ST_ACTIVE: if (!fval_q)            state_d = ST_IDLE;
            default:                           state_d = ST_SYNC;
        endcase
    end

    // FSM outputs: decide writes, drops and event pulses for this registered input sample.
    always_comb begin
        frame_open  = (state_q == ST_IDLE) && fval_rise;
        frame_close = (state_q == ST_ACTIVE) && !fval_q;
        // A line also closes when the frame ends while LVAL is still high.
        line_close  = (state_q == ST_ACTIVE) && lval_prev_q && (!lval_q || !fval_q);
        pix_en      = (state_q == ST_ACTIVE) && fval_q && lval_q && dval_q;

        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_l_d   = wr_data_l_q;
        wr_data_r_d   = wr_data_r_q;
        line_num_d    = line_num_q;
        frame_start_d = 1'b0;
        line_end_d    = 1'b0;
        frame_end_d   = 1'b0;
        line_len_d    = line_len_q;
        frame_cnt_d   = frame_cnt_q;
        ovf_d         = 1'b0;
        pix_cnt_d     = pix_cnt_q;

        if (frame_open) begin
            frame_start_d = 1'b1;
            line_num_d    = '0;
            pix_cnt_d     = '0;
        end

        if (pix_en) begin
            if ((pix_cnt_q < HACT_C) && (line_num_q < VACT_C)) begin
                wr_en_d     = 1'b1;
                wr_addr_d   = pix_cnt_q[ADDR_WIDTH-1:0];
                wr_data_l_d = data_l_q;
                wr_data_r_d = data_r_q;
            end else begin
                ovf_d = 1'b1;
            end
            // Saturating count doubles as the saturated LINE_LEN value.
            if (pix_cnt_q != CNT_MAX) begin
                pix_cnt_d = pix_cnt_q + 1'b1;
            end
        end

        if (line_close) begin
            line_end_d = 1'b1;
            line_len_d = pix_cnt_q;
            pix_cnt_d  = '0;
            if (line_num_q != VACT_C) begin
                line_num_d = line_num_q + 1'b1;
            end
        end

        if (frame_close) begin
            frame_end_d = 1'b1;
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge CCLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_l_q   <= '0;
            wr_data_r_q   <= '0;
            line_num_q    <= '0;
            frame_start_q <= 1'b0;
            line_end_q    <= 1'b0;
            frame_end_q   <= 1'b0;
            line_len_q    <= '0;
            frame_cnt_q   <= '0;
            ovf_q         <= 1'b0;
            pix_cnt_q     <= '0;
        end else begin
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_l_q   <= wr_data_l_d;
            wr_data_r_q   <= wr_data_r_d;
            line_num_q    <= line_num_d;
            frame_start_q <= frame_start_d;
            line_end_q    <= line_end_d;
            frame_end_q   <= frame_end_d;
            line_len_q    <= line_len_d;
            frame_cnt_q   <= frame_cnt_d;
            ovf_q         <= ovf_d;
            pix_cnt_q     <= pix_cnt_d;
        end
    end

    assign WR_EN       = wr_en_q;
    assign WR_ADDR     = wr_addr_q;
    assign WR_DATA_L   = wr_data_l_q;
    assign WR_DATA_R   = wr_data_r_q;
    assign LINE_NUM    = line_num_q;
    assign FRAME_START = frame_start_q;
    assign LINE_END    = line_end_q;
    assign FRAME_END   = frame_end_q;
    assign LINE_LEN    = line_len_q;
    assign FRAME_CNT   = frame_cnt_q;
    assign OVF         = ovf_q;

endmodule

// File: tb/tb_cam_capture.sv
// Bench for cam_capture with reduced geometry (HACT=20, VACT=12) so whole frames fit a short run.
// Expected responses are queued by the stimulus tasks and consumed by a negedge monitor.
// Output events carry the cycle they must appear in, so latency is checked along with values.
`timescale 1ns/1ps
module tb_cam_capture;

    localparam int PW    = 8;
    localparam int AW    = 5;
    localparam int HACT  = 20;
    localparam int VACT  = 12;
    localparam int LLMAX = (1 << (AW + 1)) - 1;

    logic          CCLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          FVAL = 1'b0, LVAL = 1'b0, DVAL = 1'b0;
    logic [PW-1:0] DATA_L = '0, DATA_R = '0;
    logic          WR_EN;
    logic [AW-1:0] WR_ADDR;
    logic [PW-1:0] WR_DATA_L, WR_DATA_R;
    logic [9:0]    LINE_NUM;
    logic          FRAME_START, LINE_END, FRAME_END, OVF;
    logic [AW:0]   LINE_LEN;
    logic [7:0]    FRAME_CNT;

    cam_capture #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW), .HACT(HACT), .VACT(VACT)) dut (
        .CCLK(CCLK), .RST_N(RST_N), .FVAL(FVAL), .LVAL(LVAL), .DVAL(DVAL),
        .DATA_L(DATA_L), .DATA_R(DATA_R), .WR_EN(WR_EN), .WR_ADDR(WR_ADDR),
        .WR_DATA_L(WR_DATA_L), .WR_DATA_R(WR_DATA_R), .LINE_NUM(LINE_NUM),
        .FRAME_START(FRAME_START), .LINE_END(LINE_END), .FRAME_END(FRAME_END),
        .LINE_LEN(LINE_LEN), .FRAME_CNT(FRAME_CNT), .OVF(OVF)
    );

    always #5 CCLK = ~CCLK;

    int cyc = 0;
    always @(posedge CCLK) cyc <= cyc + 1;

    typedef struct {int cyc; int addr; int dl; int dr;} wr_t;
    typedef struct {int cyc; int len; int ln;} le_t;
    typedef struct {int cyc; int cnt;} fe_t;

    wr_t wr_q[$];
    int  ovf_q[$];
    le_t le_q[$];
    int  fs_q[$];
    fe_t fe_q[$];

    int checks = 0, failures = 0;
    int n_wr = 0, n_ovf = 0, n_le = 0, n_fs = 0, n_fe = 0;
    int last_le_cyc = -1, last_fe_cyc = -2;

    // Reference state: frames completed and index of the line being generated.
    int exp_fcnt = 0;
    int line_idx = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every asserted output event must match the head of its queue.
    always @(negedge CCLK) begin
        wr_t w;
        le_t l;
        fe_t f;
        int  c;
        if (RST_N) begin
            if (WR_EN) begin
                n_wr++;
                if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    w = wr_q.pop_front();
                    chk("wr_cycle", cyc, w.cyc);
                    chk("wr_addr", WR_ADDR, w.addr);
                    chk("wr_data_l", WR_DATA_L, w.dl);
                    chk("wr_data_r", WR_DATA_R, w.dr);
                end
            end
            if (OVF) begin
                n_ovf++;
                if (ovf_q.size() == 0) chk("ovf_unexpected", 1, 0);
                else begin
                    c = ovf_q.pop_front();
                    chk("ovf_cycle", cyc, c);
                end
            end
            if (LINE_END) begin
                n_le++;
                last_le_cyc = cyc;
                if (le_q.size() == 0) chk("line_end_unexpected", 1, 0);
                else begin
                    l = le_q.pop_front();
                    chk("line_end_cycle", cyc, l.cyc);
                    chk("line_len", LINE_LEN, l.len);
                    chk("line_num", LINE_NUM, l.ln);
                end
            end
            if (FRAME_START) begin
                n_fs++;
                if (fs_q.size() == 0) chk("frame_start_unexpected", 1, 0);
                else begin
                    c = fs_q.pop_front();
                    chk("frame_start_cycle", cyc, c);
                    chk("frame_start_line_num", LINE_NUM, 0);
                end
            end
            if (FRAME_END) begin
                n_fe++;
                last_fe_cyc = cyc;
                if (fe_q.size() == 0) chk("frame_end_unexpected", 1, 0);
                else begin
                    f = fe_q.pop_front();
                    chk("frame_end_cycle", cyc, f.cyc);
                    chk("frame_cnt", FRAME_CNT, f.cnt);
                end
            end
        end
    end

    // One camera cycle; returns the cycle number the inputs belong to.
    task automatic drive(input bit f, input bit l, input bit d, output int stamp);
        @(posedge CCLK);
        #1;
        FVAL   = f;
        LVAL   = l;
        DVAL   = d;
        DATA_L = PW'($urandom);
        DATA_R = PW'($urandom);
        stamp  = cyc;
    endtask

    task automatic idle(input int n, input bit f);
        int s;
        for (int i = 0; i < n; i++) drive(f, 1'b0, 1'b0, s);
    endtask

    task automatic start_frame();
        int s;
        idle(3, 1'b0);
        drive(1'b1, 1'b0, 1'b0, s);
        fs_q.push_back(s + 2);
        line_idx = 0;
        idle(2, 1'b1);
    endtask

    task automatic end_frame();
        int s;
        drive(1'b0, 1'b0, 1'b0, s);
        exp_fcnt = (exp_fcnt + 1) % 256;
        fe_q.push_back('{s + 2, exp_fcnt});
        idle(2, 1'b0);
    endtask

    // One line of n LVAL cycles. mode: 0 all DVAL, 1 alternate 1,0, 2 random, 3 no DVAL.
    // With drop set, FVAL falls in the cycle after the last pixel while LVAL stays high.
    task automatic do_line(input int n, input int mode, input int pregap, input bit drop);
        int s;
        int j;
        bit d;
        j = 0;
        idle(pregap, 1'b1);
        for (int k = 0; k < n; k++) begin
            case (mode)
                0:       d = 1'b1;
                1:       d = (k % 2 == 0);
                2:       d = 1'($urandom_range(0, 1));
                default: d = 1'b0;
            endcase
            drive(1'b1, 1'b1, d, s);
            if (d) begin
                if (line_idx < VACT && j < HACT)
                    wr_q.push_back('{s + 2, j, int'(DATA_L), int'(DATA_R)});
                else
                    ovf_q.push_back(s + 2);
                j++;
            end
        end
        if (drop) drive(1'b0, 1'b1, 1'b1, s);
        else      drive(1'b1, 1'b0, 1'b0, s);
        le_q.push_back('{s + 2, (j > LLMAX) ? LLMAX : j, (line_idx + 1 > VACT) ? VACT : line_idx + 1});
        line_idx++;
        if (drop) begin
            exp_fcnt = (exp_fcnt + 1) % 256;
            fe_q.push_back('{s + 2, exp_fcnt});
            idle(3, 1'b0);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int s, w0, o0, l0, f0, e0;

        // Reset state
        repeat (3) @(posedge CCLK);
        #1;
        chk("rst_wr_en", WR_EN, 0);
        chk("rst_wr_addr", WR_ADDR, 0);
        chk("rst_wr_data_l", WR_DATA_L, 0);
        chk("rst_wr_data_r", WR_DATA_R, 0);
        chk("rst_line_num", LINE_NUM, 0);
        chk("rst_frame_start", FRAME_START, 0);
        chk("rst_line_end", LINE_END, 0);
        chk("rst_frame_end", FRAME_END, 0);
        chk("rst_line_len", LINE_LEN, 0);
        chk("rst_frame_cnt", FRAME_CNT, 0);
        chk("rst_ovf", OVF, 0);
        RST_N = 1'b1;

        // Full frames: HACT+1 pixels per line, VACT+1 lines
        for (int fr = 0; fr < 2; fr++) begin
            w0 = n_wr; o0 = n_ovf; l0 = n_le;
            start_frame();
            for (int r = 0; r < VACT + 1; r++) do_line(HACT + 1, 0, 3, 1'b0);
            idle(4, 1'b1);
            chk("line_num_hold", LINE_NUM, VACT);
            end_frame();
            idle(3, 1'b0);
            chk("line_end_per_frame", n_le - l0, VACT + 1);
            chk("ovf_per_frame", n_ovf - o0, VACT + HACT + 1);
            chk("wr_per_frame", n_wr - w0, VACT * HACT);
        end

        // Alternating DVAL, saturating LINE_LEN, zero-pixel line
        start_frame();
        w0 = n_wr;
        do_line(31, 1, 3, 1'b0);
        idle(3, 1'b1);
        chk("alt_writes", n_wr - w0, 16);
        do_line(70, 0, 3, 1'b0);
        idle(3, 1'b1);
        chk("line_len_sat", LINE_LEN, LLMAX);
        do_line(5, 3, 3, 1'b0);
        idle(3, 1'b1);
        chk("line_len_zero", LINE_LEN, 0);
        end_frame();

        // Random frames
        for (int fr = 0; fr < 3; fr++) begin
            start_frame();
            for (int r = 0, nl = $urandom_range(1, VACT + 3); r < nl; r++)
                do_line($urandom_range(1, 70), $urandom_range(0, 3), $urandom_range(1, 4), 1'b0);
            end_frame();
        end

        // FVAL drops while LVAL is high after 15 pixels
        start_frame();
        do_line(15, 0, 3, 1'b1);
        idle(3, 1'b0);
        chk("drop_line_len", LINE_LEN, 15);
        chk("drop_same_cycle", last_le_cyc, last_fe_cyc);

        // Plain reset, then 257 frames for FRAME_CNT wrap
        idle(5, 1'b0);
        RST_N = 1'b0;
        idle(2, 1'b0);
        chk("rst2_frame_cnt", FRAME_CNT, 0);
        RST_N = 1'b1;
        exp_fcnt = 0;
        for (int fr = 0; fr < 257; fr++) begin
            start_frame();
            end_frame();
        end
        idle(3, 1'b0);
        chk("frame_cnt_wrap", FRAME_CNT, 1);

        // Reset asserted and released inside a frame
        start_frame();
        idle(4, 1'b1);
        RST_N = 1'b0;
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b1, s);
        w0 = n_wr; f0 = n_fs; e0 = n_fe;
        RST_N = 1'b1;
        exp_fcnt = 0;
        for (int i = 0; i < 40; i++) drive(1'b1, (i % 10) < 7, 1'b1, s);
        idle(4, 1'b0);
        chk("sync_no_writes", n_wr - w0, 0);
        chk("sync_no_frame_end", n_fe - e0, 0);
        chk("sync_no_frame_start", n_fs - f0, 0);
        start_frame();
        do_line(HACT, 0, 3, 1'b0);
        do_line(HACT, 2, 3, 1'b0);
        end_frame();
        idle(3, 1'b0);
        chk("resume_frame_start_once", n_fs - f0, 1);
        chk("resume_frame_cnt", FRAME_CNT, 1);

        // Every queued expectation must have been consumed
        idle(5, 1'b0);
        chk("wr_q_left", wr_q.size(), 0);
        chk("ovf_q_left", ovf_q.size(), 0);
        chk("le_q_left", le_q.size(), 0);
        chk("fs_q_left", fs_q.size(), 0);
        chk("fe_q_left", fe_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
